vector_checker: RTL and testbench
=================================

Name: vector_checker

Overview:
Synthesizable response-checking counterpart to our stimulus-only combinational benches. It plays a stored table of {input, expected-output} vectors into a combinational DUT and samples the DUT's response after a programmable settle time. It compares each response against the expected value, counts mismatches and reports pass/fail. It sits beside the DUT on FPGA bring-up boards and inside self-checking simulation tops.

Parameters:
IN_W, 3, width of stimulus applied to the DUT
OUT_W, 1, width of the DUT response checked
NVEC, 8, number of vectors in the table (2..256)
SETTLE, 1, clock cycles between applying a vector and sampling the response (1..15)
AW, $clog2(NVEC), vector address width (derived, not overridden)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  run request, sampled in IDLE or DONE
wr_en  in  1  table write strobe, honoured only when busy=0
wr_addr  in  AW  table write address
wr_data  in  IN_W+OUT_W  {stimulus, expected}, stimulus in the MSBs
dut_in  out  IN_W  stimulus to the DUT
dut_out  in  OUT_W  response from the DUT
busy  out  1  run in progress
done  out  1  run finished, held until the next start
pass  out  1  done and err_count==0
mismatch  out  1  one-cycle pulse on a failing compare
err_count  out  8  saturating mismatch count
first_fail  out  AW  index of the first failing vector, valid when err_count!=0
vec_idx  out  AW  index of the vector currently applied

Behaviour:
- The only clock is clk. Reset is asynchronous and active-high on port reset.
- Reset values: state=IDLE; dut_in, err_count, first_fail, vec_idx all 0; busy, done, pass, mismatch all 0. The table contents are not reset.
- Table: NVEC x (IN_W+OUT_W) registers. Writes are synchronous. A write while busy=1 is dropped. Writes to addresses >= NVEC are dropped.
- FSM states: IDLE, APPLY, WAIT, SAMPLE, DONE.
- IDLE/DONE + start=1 -> APPLY. This transition clears vec_idx, err_count and first_fail, and drops done and pass. busy=1 from the next cycle.
- APPLY: dut_in <= table[vec_idx].stim; load settle counter with SETTLE-1; -> WAIT. If SETTLE==1, go -> SAMPLE directly.
- WAIT: decrement the counter each cycle; at 0 -> SAMPLE.
- SAMPLE: compare dut_out against table[vec_idx].exp.
  - On mismatch: mismatch=1 for exactly this cycle; err_count increments and saturates at 255; if err_count was 0, first_fail <= vec_idx.
  - If vec_idx==NVEC-1 -> DONE; else vec_idx++ and -> APPLY.
- Per-vector latency is SETTLE+1 cycles. A full run takes NVEC*(SETTLE+1) cycles from start to done.
- DONE: busy=0, done=1, pass=(err_count==0). dut_in holds the last vector. Stays in DONE until start.
- start while busy=1 is ignored; there is no abort.
- Reset asserted mid-run returns the block to IDLE immediately and asynchronously. No partial results are retained.
- An X or Z on dut_out counts as a mismatch in simulation (case-inequality compare). In synthesis this is an ordinary compare.

Decomposition:
- Package vector_checker_pkg holds:
  - state enum state_t {IDLE, APPLY, WAIT, SAMPLE, DONE}
  - ERR_MAX=8'd255
  - helper functions vec_stim()/vec_exp() that split a table word
- One natural sub-module: vector_rom_ram, the NVEC-entry write-port table with a combinational read by vec_idx.
- The FSM, counters and compare stay in vector_checker.

Test Plan:
- Load the 8 vectors of y = ~b&~c | a&~b (000->1, 001->0, 010->0, 011->0, 100->1, 101->1, 110->0, 111->0), attach a correct DUT, start -> done after 16 cycles, pass=1, err_count=0, mismatch never pulses, dut_in steps 0..7.
- Same table with entry 5 expected flipped to 0 -> exactly one mismatch pulse at vec_idx=5, err_count=1, first_fail=5, pass=0.
- SETTLE=3 with a DUT whose output is registered (2-cycle latency) -> pass=1. SETTLE=1 with the same DUT -> err_count>0.
- Assert reset during WAIT of vector 4 -> all outputs return to reset values in the same cycle. A new start then runs cleanly from vector 0 with err_count=0.
- wr_en pulse while busy=1 changes entry 2 -> table unchanged, run passes. start pulse mid-run -> ignored, done asserts once at the normal time.
- DUT output tied to 1 with NVEC=256, all expected 0 -> err_count saturates at 255 (not wrapped), first_fail=0.

Source files
------------

// File: rtl/vector_checker_pkg.sv
// Shared types and helpers for the vector checker: FSM state encoding,
// error-count ceiling and splitting of a {stimulus, expected} table word.
package vector_checker_pkg;

   localparam int WORD_MAX = 32;
   localparam logic [7:0] ERR_MAX = 8'd255;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      APPLY  = 3'd1,
      WAIT   = 3'd2,
      SAMPLE = 3'd3,
      DONE   = 3'd4
   } state_t;

   // Table words are zero-extended to WORD_MAX bits; the caller casts the
   // result back to its own width.
   function automatic logic [WORD_MAX-1:0] vec_stim(input logic [WORD_MAX-1:0] word,
                                                    input int out_w);
      return word >> out_w;
   endfunction

   function automatic logic [WORD_MAX-1:0] vec_exp(input logic [WORD_MAX-1:0] word,
                                                   input int out_w);
      return word & ((WORD_MAX'(1) << out_w) - WORD_MAX'(1));
   endfunction

endpackage

// File: rtl/vector_rom_ram.sv
// Vector table: NVEC words with one synchronous write port and an
// asynchronous read port addressed by the currently applied vector index.
module vector_rom_ram #(
   parameter int NVEC   = 8,
   parameter int WORD_W = 4,
   parameter int AW     = $clog2(NVEC)
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [WORD_W-1:0] wr_data,
   input  logic [AW-1:0]     rd_addr,
   output logic [WORD_W-1:0] rd_data
);

   logic [WORD_W-1:0] mem [NVEC];

   // Out-of-range addresses only exist when NVEC is not a power of two.
   always_ff @(posedge clk) begin
      if (wr_en && (int'(wr_addr) < NVEC))
         mem[wr_addr] <= wr_data;
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/vector_checker.sv
// Plays a stored {stimulus, expected} table into a combinational DUT, samples
// its response SETTLE cycles later and tallies mismatches.
module vector_checker
   import vector_checker_pkg::*;
#(
   parameter int IN_W   = 3,
   parameter int OUT_W  = 1,
   parameter int NVEC   = 8,
   parameter int SETTLE = 1,
   localparam int AW    = $clog2(NVEC)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  wr_en,
   input  logic [AW-1:0]         wr_addr,
   input  logic [IN_W+OUT_W-1:0] wr_data,
   output logic [IN_W-1:0]       dut_in,
   input  logic [OUT_W-1:0]      dut_out,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic                  mismatch,
   output logic [7:0]            err_count,
   output logic [AW-1:0]         first_fail,
   output logic [AW-1:0]         vec_idx
);

   localparam int WORD_W = IN_W + OUT_W;

   state_t            state;
   logic [3:0]        settle_cnt;
   logic [WORD_W-1:0] rd_word;
   logic [IN_W-1:0]   cur_stim;
   logic [OUT_W-1:0]  cur_exp;
   logic              miss;

   vector_rom_ram #(
      .NVEC   (NVEC),
      .WORD_W (WORD_W),
      .AW     (AW)
   ) u_table (
      .clk     (clk),
      .wr_en   (wr_en && !busy),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .rd_addr (vec_idx),
      .rd_data (rd_word)
   );

   assign cur_stim = IN_W'(vec_stim(WORD_MAX'(rd_word), OUT_W));
   assign cur_exp  = OUT_W'(vec_exp(WORD_MAX'(rd_word), OUT_W));

   // Case-inequality so an X/Z response is flagged in simulation.
   assign miss     = (state == SAMPLE) && (dut_out !== cur_exp);
   assign mismatch = miss;
   assign busy     = (state == APPLY) || (state == WAIT) || (state == SAMPLE);
   assign done     = (state == DONE);
   assign pass     = done && (err_count == 8'd0);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         dut_in     <= '0;
         err_count  <= '0;
         first_fail <= '0;
         vec_idx    <= '0;
         settle_cnt <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state      <= APPLY;
                  vec_idx    <= '0;
                  err_count  <= '0;
                  first_fail <= '0;
               end
            end
            APPLY: begin
               dut_in     <= cur_stim;
               settle_cnt <= 4'(SETTLE - 1);
               state      <= (SETTLE == 1) ? SAMPLE : WAIT;
            end
            // Counter holds the WAIT cycles still to go, so the last one exits.
            WAIT: begin
               settle_cnt <= settle_cnt - 4'd1;
               if (settle_cnt == 4'd1)
                  state <= SAMPLE;
            end
            SAMPLE: begin
               if (miss) begin
                  if (err_count != ERR_MAX)
                     err_count <= err_count + 8'd1;
                  if (err_count == 8'd0)
                     first_fail <= vec_idx;
               end
               if (int'(vec_idx) == NVEC - 1) begin
                  state <= DONE;
               end else begin
                  vec_idx <= vec_idx + AW'(1);
                  state   <= APPLY;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vector_checker.sv
// Directed bench: combinational and 2-cycle registered DUT models, a
// saturating-error instance, reset mid-run and write/start while busy.
module tb_vector_checker;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   int checks = 0;
   int passed = 0;

   // Shared table write bus for the three 8-entry instances
   logic       wr_en = 1'b0;
   logic [2:0] wr_addr = '0;
   logic [3:0] wr_data = '0;

   logic       a_start = 1'b0, b_start = 1'b0, c_start = 1'b0, d_start = 1'b0;
   logic [2:0] a_in, b_in, c_in, d_in;
   logic       a_out, b_out, c_out, d_out;
   logic       a_busy, a_done, a_pass, a_mis;
   logic       b_busy, b_done, b_pass, b_mis;
   logic       c_busy, c_done, c_pass, c_mis;
   logic       d_busy, d_done, d_pass, d_mis;
   logic [7:0] a_err, b_err, c_err, d_err;
   logic [2:0] a_ff, a_idx, b_ff, b_idx, c_ff, c_idx;
   logic [7:0] d_ff, d_idx;
   logic       d_wr_en = 1'b0;
   logic [7:0] d_wr_addr = '0;
   logic [3:0] d_wr_data = '0;

   // Expected column of y = ~b&~c | a&~b, indexed by {a,b,c}
   logic [7:0] truth = 8'b0011_0001;

   function automatic logic f(input logic [2:0] x);
      return (~x[1] & ~x[0]) | (x[2] & ~x[1]);
   endfunction

   logic [1:0] b_pipe, c_pipe;
   always @(posedge clk) begin
      b_pipe <= {b_pipe[0], f(b_in)};
      c_pipe <= {c_pipe[0], f(c_in)};
   end
   assign a_out = f(a_in);
   assign b_out = b_pipe[1];
   assign c_out = c_pipe[1];
   assign d_out = 1'b1;

   vector_checker #(.IN_W(3), .OUT_W(1), .NVEC(8), .SETTLE(1)) u_a (
      .clk(clk), .reset(reset), .start(a_start), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .dut_in(a_in), .dut_out(a_out), .busy(a_busy), .done(a_done),
      .pass(a_pass), .mismatch(a_mis), .err_count(a_err), .first_fail(a_ff), .vec_idx(a_idx));

   vector_checker #(.IN_W(3), .OUT_W(1), .NVEC(8), .SETTLE(3)) u_b (
      .clk(clk), .reset(reset), .start(b_start), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .dut_in(b_in), .dut_out(b_out), .busy(b_busy), .done(b_done),
      .pass(b_pass), .mismatch(b_mis), .err_count(b_err), .first_fail(b_ff), .vec_idx(b_idx));

   vector_checker #(.IN_W(3), .OUT_W(1), .NVEC(8), .SETTLE(1)) u_c (
      .clk(clk), .reset(reset), .start(c_start), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .dut_in(c_in), .dut_out(c_out), .busy(c_busy), .done(c_done),
      .pass(c_pass), .mismatch(c_mis), .err_count(c_err), .first_fail(c_ff), .vec_idx(c_idx));

   vector_checker #(.IN_W(3), .OUT_W(1), .NVEC(256), .SETTLE(1)) u_d (
      .clk(clk), .reset(reset), .start(d_start), .wr_en(d_wr_en), .wr_addr(d_wr_addr),
      .wr_data(d_wr_data), .dut_in(d_in), .dut_out(d_out), .busy(d_busy), .done(d_done),
      .pass(d_pass), .mismatch(d_mis), .err_count(d_err), .first_fail(d_ff), .vec_idx(d_idx));

   task automatic load_word(input logic [2:0] addr, input logic [3:0] data);
      @(negedge clk);
      wr_en = 1'b1; wr_addr = addr; wr_data = data;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic load_good();
      for (int i = 0; i < 8; i++) load_word(3'(i), {3'(i), truth[i]});
   endtask

   task automatic test_reset();
      @(negedge clk); @(negedge clk);
      checks++; if (a_in !== 3'd0) $display("FAIL reset_dut_in got %0d want 0", a_in); else passed++;
      checks++; if (a_busy !== 1'b0) $display("FAIL reset_busy got %b want 0", a_busy); else passed++;
      checks++; if (a_done !== 1'b0) $display("FAIL reset_done got %b want 0", a_done); else passed++;
      checks++; if (a_pass !== 1'b0) $display("FAIL reset_pass got %b want 0", a_pass); else passed++;
      checks++; if (a_mis !== 1'b0) $display("FAIL reset_mismatch got %b want 0", a_mis); else passed++;
      checks++; if (a_err !== 8'd0) $display("FAIL reset_err got %0d want 0", a_err); else passed++;
      checks++; if ({a_ff, a_idx} !== 6'd0) $display("FAIL reset_idx got ff=%0d idx=%0d want 0", a_ff, a_idx); else passed++;
      reset = 1'b0;
   endtask

   task automatic test_good_run();
      int cyc = 0, pulses = 0, steps = 0;
      logic [2:0] prev;
      bit step_ok = 1'b1;
      load_good();
      prev = a_in;
      @(negedge clk); a_start = 1'b1;
      @(negedge clk); a_start = 1'b0;
      while (!a_done && cyc < 100) begin
         @(negedge clk); cyc++;
         if (a_mis) pulses++;
         if (a_in !== prev) begin
            if (a_in !== prev + 3'd1) step_ok = 1'b0;
            steps++;
            prev = a_in;
         end
      end
      checks++; if (cyc !== 16) $display("FAIL good_latency got %0d want 16", cyc); else passed++;
      checks++; if (a_pass !== 1'b1) $display("FAIL good_pass got %b want 1", a_pass); else passed++;
      checks++; if (a_err !== 8'd0) $display("FAIL good_err got %0d want 0", a_err); else passed++;
      checks++; if (pulses !== 0) $display("FAIL good_pulses got %0d want 0", pulses); else passed++;
      checks++; if (!step_ok || steps !== 7 || a_in !== 3'd7)
         $display("FAIL good_stim_seq got steps=%0d last=%0d ok=%b want 7/7/1", steps, a_in, step_ok);
      else passed++;
      checks++; if (a_busy !== 1'b0) $display("FAIL good_busy_done got %b want 0", a_busy); else passed++;
   endtask

   task automatic test_fail_entry();
      int cyc = 0, pulses = 0;
      logic [2:0] pidx = '0;
      load_word(3'd5, {3'd5, 1'b0});
      @(negedge clk); a_start = 1'b1;
      @(negedge clk); a_start = 1'b0;
      while (!a_done && cyc < 100) begin
         @(negedge clk); cyc++;
         if (a_mis) begin pulses++; pidx = a_idx; end
      end
      checks++; if (pulses !== 1) $display("FAIL flip_pulses got %0d want 1", pulses); else passed++;
      checks++; if (pidx !== 3'd5) $display("FAIL flip_pulse_idx got %0d want 5", pidx); else passed++;
      checks++; if (a_err !== 8'd1) $display("FAIL flip_err got %0d want 1", a_err); else passed++;
      checks++; if (a_ff !== 3'd5) $display("FAIL flip_first_fail got %0d want 5", a_ff); else passed++;
      checks++; if (a_pass !== 1'b0 || a_done !== 1'b1)
         $display("FAIL flip_pass got pass=%b done=%b want 0/1", a_pass, a_done);
      else passed++;
   endtask

   task automatic test_settle();
      int cyc = 0, b_cyc = 0;
      load_good();
      @(negedge clk); b_start = 1'b1; c_start = 1'b1;
      @(negedge clk); b_start = 1'b0; c_start = 1'b0;
      while (!(b_done && c_done) && cyc < 300) begin
         @(negedge clk); cyc++;
         if (b_done && b_cyc == 0) b_cyc = cyc;
      end
      checks++; if (b_cyc !== 32) $display("FAIL settle3_latency got %0d want 32", b_cyc); else passed++;
      checks++; if (b_pass !== 1'b1 || b_err !== 8'd0)
         $display("FAIL settle3_pass got pass=%b err=%0d want 1/0", b_pass, b_err);
      else passed++;
      checks++; if (c_done !== 1'b1 || c_err == 8'd0 || c_pass !== 1'b0)
         $display("FAIL settle1_regdut got done=%b err=%0d pass=%b want 1/>0/0", c_done, c_err, c_pass);
      else passed++;
   endtask

   task automatic test_reset_mid();
      int cyc = 0;
      @(negedge clk); b_start = 1'b1;
      @(negedge clk); b_start = 1'b0;
      while (b_idx !== 3'd4 && cyc < 100) begin @(negedge clk); cyc++; end
      @(negedge clk);  // vector 4 has left APPLY and is settling
      checks++; if (b_busy !== 1'b1 || b_idx !== 3'd4 || b_in !== 3'd4)
         $display("FAIL midrst_pre got busy=%b idx=%0d in=%0d want 1/4/4", b_busy, b_idx, b_in);
      else passed++;
      #2 reset = 1'b1;
      #1;
      checks++; if ({b_busy, b_done, b_pass, b_mis} !== 4'b0000)
         $display("FAIL midrst_flags got %b want 0000", {b_busy, b_done, b_pass, b_mis});
      else passed++;
      checks++; if (b_in !== 3'd0 || b_idx !== 3'd0 || b_err !== 8'd0 || b_ff !== 3'd0)
         $display("FAIL midrst_values got in=%0d idx=%0d err=%0d ff=%0d want 0", b_in, b_idx, b_err, b_ff);
      else passed++;
      @(negedge clk); reset = 1'b0;
      @(negedge clk); b_start = 1'b1;
      @(negedge clk); b_start = 1'b0;
      cyc = 0;
      while (!b_done && cyc < 100) begin @(negedge clk); cyc++; end
      checks++; if (cyc !== 32 || b_pass !== 1'b1 || b_err !== 8'd0)
         $display("FAIL midrst_rerun got cyc=%0d pass=%b err=%0d want 32/1/0", cyc, b_pass, b_err);
      else passed++;
   endtask

   task automatic test_busy_write();
      int cyc = 0, rises = 0, first = 0;
      logic last_done;
      @(negedge clk); a_start = 1'b1;
      @(negedge clk); a_start = 1'b0;
      last_done = a_done;
      while (cyc < 30) begin
         @(negedge clk); cyc++;
         if (a_done && !last_done) begin rises++; if (first == 0) first = cyc; end
         last_done = a_done;
         wr_en   = (cyc == 3);
         wr_addr = 3'd2;
         wr_data = {3'd2, 1'b1};
         a_start = (cyc == 6);
      end
      wr_en = 1'b0; a_start = 1'b0;
      checks++; if (first !== 16 || rises !== 1)
         $display("FAIL busy_start_done got at=%0d rises=%0d want 16/1", first, rises);
      else passed++;
      checks++; if (a_pass !== 1'b1 || a_err !== 8'd0)
         $display("FAIL busy_write_drop got pass=%b err=%0d want 1/0", a_pass, a_err);
      else passed++;
   endtask

   task automatic test_saturate();
      int cyc = 0;
      for (int i = 0; i < 256; i++) begin
         @(negedge clk);
         d_wr_en = 1'b1; d_wr_addr = 8'(i); d_wr_data = {3'(i), 1'b0};
      end
      @(negedge clk); d_wr_en = 1'b0; d_start = 1'b1;
      @(negedge clk); d_start = 1'b0;
      while (!d_done && cyc < 1000) begin @(negedge clk); cyc++; end
      checks++; if (cyc !== 512) $display("FAIL sat_latency got %0d want 512", cyc); else passed++;
      checks++; if (d_err !== 8'd255) $display("FAIL sat_err got %0d want 255", d_err); else passed++;
      checks++; if (d_ff !== 8'd0) $display("FAIL sat_first_fail got %0d want 0", d_ff); else passed++;
      checks++; if (d_pass !== 1'b0 || d_idx !== 8'd255 || d_in !== 3'd7)
         $display("FAIL sat_final got pass=%b idx=%0d in=%0d want 0/255/7", d_pass, d_idx, d_in);
      else passed++;
   endtask

   initial begin
      test_reset();
      test_good_run();
      test_fail_entry();
      test_settle();
      test_reset_mid();
      test_busy_write();
      test_saturate();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
